packet_deserializer: RTL and testbench
======================================

PACKET_DESERIALIZER -- requirements
Module: packet_deserializer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per packet (1..31).
REQ-002 SHALL have parameter HEADER, default 8'hA5, start-of-packet byte value.
REQ-003 SHALL have parameter TIMEOUT, default 32, idle-cycle abort limit (used only under PKT_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port din  input  8  byte stream from upstream serializer.
REQ-007 SHALL have port din_valid  input  1  din qualifier; byte accepted on any rising edge with din_valid=1.
REQ-008 SHALL have port dout  output  8  recovered payload byte.
REQ-009 SHALL have port dout_valid  output  1  dout qualifier.
REQ-010 SHALL have port dout_last  output  1  marks final payload byte, valid with dout_valid only.
REQ-011 SHALL have port pkt_len  output  5  length of last good packet, held until next good packet.
REQ-012 SHALL have port pkt_done  output  1  one-cycle pulse on checksum pass.
REQ-013 SHALL have port pkt_err  output  1  one-cycle pulse on bad length, bad checksum or timeout.

Function
REQ-014 SHALL parse frames: HEADER, LEN (1..MAX_LEN), LEN payload bytes, CHK, where CHK equals (LEN + sum of payload) mod 256.
REQ-015 SHALL implement states IDLE, LEN, PAYLOAD, CHECK, DRAIN; every state except DRAIN holds when din_valid=0.
REQ-016 IDLE: byte==HEADER -> LEN; any other byte discarded, no pulse.
REQ-017 LEN: byte of 0 or >MAX_LEN -> pkt_err pulse next cycle, -> IDLE; else store LEN, clear running sum to LEN, -> PAYLOAD.
REQ-018 PAYLOAD: each byte written to buffer at index 0..LEN-1 and added to 8-bit running sum (wrap-around); after byte LEN -> CHECK.
REQ-019 CHECK: byte==running sum -> pkt_done pulse, pkt_len<=LEN, -> DRAIN; mismatch -> pkt_err pulse, buffer discarded, -> IDLE; both pulses occur the cycle after CHK accepted.
REQ-020 DRAIN: dout_valid=1 for exactly LEN consecutive cycles, bytes in buffer order, first byte in same cycle as pkt_done; dout_last=1 on byte LEN; then -> IDLE.
REQ-021 Bytes arriving during DRAIN SHALL be dropped, including HEADER; no pulse generated.
REQ-022 A HEADER value inside LEN/PAYLOAD/CHECK SHALL be treated as ordinary data (no resync).
REQ-023 dout SHALL be 8'h00 whenever dout_valid=0.
REQ-024 pkt_done and pkt_err SHALL never be asserted in the same cycle.

Reset
REQ-025 rst=0 on a rising edge SHALL force state IDLE, dout=0, dout_valid=0, dout_last=0, pkt_len=0, pkt_done=0, pkt_err=0, running sum=0, timeout counter=0.
REQ-026 Reset mid-packet or mid-DRAIN SHALL abort without any pulse; buffer contents need not be cleared.
REQ-027 Byte presented in the reset cycle SHALL be ignored.

Configuration
REQ-028 Macro PKT_TIMEOUT_EN defined: counter of consecutive din_valid=0 cycles in LEN/PAYLOAD/CHECK; reaching TIMEOUT -> pkt_err pulse next cycle, -> IDLE; counter clears on any accepted byte and in IDLE/DRAIN.
REQ-029 Macro PKT_TIMEOUT_EN undefined: no counter logic; parser waits indefinitely mid-packet.

Verification
REQ-030 A5,03,11,22,33,69 contiguous -> pkt_done 1 cycle after 69; dout 11,22,33 on 3 consecutive cycles, dout_last with 33, pkt_len=3.
REQ-031 A5,10, sixteen bytes of FF, CHK=00 (wrapped sum 0x100+0x10-0x10... i.e. (16+16*255) mod 256=0x00) -> pkt_done, 16 FF bytes, dout_last on 16th.
REQ-032 A5,02,01,01,05 -> pkt_err pulse, no dout_valid, pkt_len unchanged.
REQ-033 A5,00 and A5,11 (MAX_LEN=16) -> pkt_err each after LEN byte, back to IDLE; following valid frame A5,01,7F,80 decodes.
REQ-034 A5,02,AA, then din_valid=0 for 40 cycles, then BB,67 -> with PKT_TIMEOUT_EN pkt_err at idle cycle 32 and BB,67 discarded; without it pkt_done and dout AA,BB.
REQ-035 rst=0 for 1 cycle during PAYLOAD of A5,04,... -> no pulse, all outputs 0; subsequent A5,01,05,06 -> pkt_done, dout=05.

Source files
------------

// File: rtl/packet_deserializer.sv
// packet_deserializer: parses HEADER/LEN/payload/CHK frames and replays good payloads on dout; optional idle abort under `PKT_TIMEOUT_EN`.
// Pulses appear one cycle after the deciding byte. There is no backpressure: bytes arriving while draining are dropped.
module packet_deserializer #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_last,
  output logic [4:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err
);
  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 31 || TIMEOUT < 1) begin : g_bad_params
    $error("packet_deserializer: MAX_LEN must be 1..31 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_len;
  logic [4:0] r_idx;
  logic [7:0] r_sum;
  logic [7:0] r_buf [0:(1<<IW)-1];

  logic w_in_pkt;
  logic w_len_ok;
  logic w_last_idx;
  logic w_tmo_hit;
  logic w_done;
  logic w_err;

  assign w_in_pkt   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  assign w_len_ok   = (din != 8'd0) && (din <= MAX_LEN_B);
  assign w_last_idx = (r_idx == r_len - 5'd1);

`ifdef PKT_TIMEOUT_EN
  localparam int           TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo;

  // Counts consecutive starved cycles while a frame is open.
  assign w_tmo_hit = w_in_pkt && !din_valid && (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (!w_in_pkt || din_valid || w_tmo_hit) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TW'(1);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (din_valid && din == HEADER) w_next = S_LEN;
      end
      S_LEN: begin
        if (din_valid) begin
          if (w_len_ok) begin
            w_next = S_PAYLOAD;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (din_valid && w_last_idx) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (din_valid) begin
          if (din == r_sum) begin
            w_done = 1'b1;
            w_next = S_DRAIN;
          end else begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (w_last_idx) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_err  = 1'b1;
      w_next = S_IDLE;
    end
  end

  always_comb begin
    dout       = 8'h00;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    if (r_state == S_DRAIN) begin
      dout       = r_buf[r_idx[IW-1:0]];
      dout_valid = 1'b1;
      dout_last  = w_last_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len    <= 5'd0;
      r_idx    <= 5'd0;
      r_sum    <= 8'd0;
      pkt_len  <= 5'd0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      pkt_done <= w_done;
      pkt_err  <= w_err;
      if (w_done) pkt_len <= r_len;
      case (r_state)
        S_LEN: begin
          if (din_valid && w_len_ok) begin
            r_len <= din[4:0];
            r_sum <= din;
            r_idx <= 5'd0;
          end
        end
        S_PAYLOAD: begin
          if (din_valid) begin
            r_sum <= r_sum + din;
            r_idx <= w_last_idx ? 5'd0 : r_idx + 5'd1;
          end
        end
        S_DRAIN: begin
          r_idx <= w_last_idx ? 5'd0 : r_idx + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Payload store needs no reset; contents are only read after a full frame.
  always_ff @(posedge clk) begin
    if (rst && r_state == S_PAYLOAD && din_valid) begin
      r_buf[r_idx[IW-1:0]] <= din;
    end
  end

endmodule

// File: tb/tb_packet_deserializer.sv
// Randomized and directed bench for packet_deserializer against a frame-level model.
module tb_packet_deserializer;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] HDR     = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_last;
  logic [4:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;

  packet_deserializer #(.MAX_LEN(MAX_LEN), .HEADER(HDR), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .pkt_len(pkt_len), .pkt_done(pkt_done), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  bq_t        q_out;
  bit         q_last[$];
  int         n_done  = 0;
  int         n_err   = 0;
  logic [4:0] exp_len = 5'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge pass, then observe just after it.
  task automatic tick(input logic v, input logic [7:0] b);
    din_valid = v;
    din       = b;
    @(posedge clk);
    #1;
    check("done_err_exclusive", {31'd0, pkt_done & pkt_err}, 32'd0);
    if (!dout_valid) begin
      check("dout_zero_when_idle", {24'd0, dout}, 32'd0);
      check("last_only_with_valid", {31'd0, dout_last}, 32'd0);
    end else begin
      q_out.push_back(dout);
      q_last.push_back(dout_last);
    end
    if (pkt_done) begin
      n_done++;
      check("first_byte_with_done", {31'd0, dout_valid}, 32'd1);
    end
    if (pkt_err) n_err++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
  endtask

  task automatic send(input bq_t f, input int maxgap);
    foreach (f[i]) begin
      idle($urandom_range(0, maxgap));
      tick(1'b1, f[i]);
    end
  endtask

  task automatic clear_obs();
    q_out.delete();
    q_last.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // Reference: CHK = (LEN + sum(payload)) mod 256; chk_xor != 0 corrupts it.
  function automatic bq_t build(input bq_t pl, input logic [7:0] len_f, input logic [7:0] chk_xor);
    bq_t f;
    int  sum;
    f.push_back(HDR);
    f.push_back(len_f);
    sum = int'(len_f);
    foreach (pl[i]) begin
      f.push_back(pl[i]);
      sum += int'(pl[i]);
    end
    f.push_back(8'(sum % 256) ^ chk_xor);
    return f;
  endfunction

  function automatic bq_t rand_pl(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(($urandom_range(0, 3) == 0) ? HDR : 8'($urandom));
    return p;
  endfunction

  task automatic check_frame(input string tag, input int exp_done, input int exp_err, input bq_t pl);
    idle(MAX_LEN + 4);
    check({tag, "_done_cnt"}, n_done, exp_done);
    check({tag, "_err_cnt"}, n_err, exp_err);
    check({tag, "_out_cnt"}, q_out.size(), pl.size());
    for (int i = 0; i < pl.size() && i < q_out.size(); i++) begin
      check({tag, "_byte"}, {24'd0, q_out[i]}, {24'd0, pl[i]});
      check({tag, "_last"}, {31'd0, q_last[i]}, (i == pl.size() - 1) ? 32'd1 : 32'd0);
    end
    if (exp_done > 0) exp_len = 5'(pl.size());
    check({tag, "_pkt_len"}, {27'd0, pkt_len}, {27'd0, exp_len});
    clear_obs();
  endtask

  initial begin
    bq_t f;
    bq_t pl;
    int  kind;
    logic [7:0] junk;

    // Reset state, and the byte presented during reset is ignored.
    rst = 1'b0;
    tick(1'b0, 8'h00);
    tick(1'b1, HDR);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout_last", {31'd0, dout_last}, 32'd0);
    check("rst_pkt_len", {27'd0, pkt_len}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
    rst = 1'b1;
    clear_obs();
    f = '{8'h01, 8'h05, 8'h06};
    send(f, 0);
    check_frame("rst_byte_ignored", 0, 0, '{});

    // Basic contiguous frame with cycle-exact output checks.
    f = '{HDR, 8'h03, 8'h11, 8'h22, 8'h33};
    send(f, 0);
    tick(1'b1, 8'h69);
    check("basic_done", {31'd0, pkt_done}, 32'd1);
    check("basic_b0", {24'd0, dout}, 32'h11);
    check("basic_b0_last", {31'd0, dout_last}, 32'd0);
    tick(1'b0, 8'h00);
    check("basic_done_pulse", {31'd0, pkt_done}, 32'd0);
    check("basic_b1", {24'd0, dout}, 32'h22);
    tick(1'b0, 8'h00);
    check("basic_b2", {24'd0, dout}, 32'h33);
    check("basic_b2_last", {31'd0, dout_last}, 32'd1);
    tick(1'b0, 8'h00);
    check("basic_end_valid", {31'd0, dout_valid}, 32'd0);
    check("basic_pkt_len", {27'd0, pkt_len}, 32'd3);
    check_frame("basic", 1, 0, '{8'h11, 8'h22, 8'h33});

    // Maximum length with checksum wrap-around.
    pl = '{};
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'hFF);
    f = build(pl, 8'(MAX_LEN), 8'h00);
    check("maxlen_chk_value", {24'd0, f[f.size()-1]}, 32'h00);
    send(f, 0);
    check_frame("maxlen", 1, 0, pl);

    // Bad checksum keeps the previous pkt_len.
    f = '{HDR, 8'h02, 8'h01, 8'h01, 8'h05};
    send(f, 0);
    check_frame("bad_chk", 0, 1, '{});

    // Zero and oversize length, each erroring right after the LEN byte.
    tick(1'b1, HDR);
    tick(1'b1, 8'h00);
    check("len0_err", {31'd0, pkt_err}, 32'd1);
    tick(1'b0, 8'h00);
    check("len0_err_pulse", {31'd0, pkt_err}, 32'd0);
    tick(1'b1, HDR);
    tick(1'b1, 8'(MAX_LEN + 1));
    check("len_big_err", {31'd0, pkt_err}, 32'd1);
    f = '{HDR, 8'h01, 8'h7F, 8'h80};
    send(f, 0);
    check_frame("after_bad_len", 1, 2, '{8'h7F});

    // HEADER value inside a frame is just data.
    pl = '{HDR, HDR};
    send(build(pl, 8'h02, 8'h00), 1);
    check_frame("hdr_as_data", 1, 0, pl);

    // A whole frame arriving during DRAIN is dropped.
    pl = rand_pl(8);
    send(build(pl, 8'h08, 8'h00), 0);
    f = '{HDR, 8'h01, 8'h05, 8'h06};
    send(f, 0);
    check_frame("drain_drop", 1, 0, pl);

    // Long starvation mid-payload.
    f = '{HDR, 8'h02, 8'hAA};
    send(f, 0);
`ifdef PKT_TIMEOUT_EN
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 8'h00);
      check("tmo_err_cycle", {31'd0, pkt_err}, (i == 32) ? 32'd1 : 32'd0);
    end
    f = '{8'hBB, 8'h67};
    send(f, 0);
    check_frame("timeout", 0, 1, '{});
`else
    idle(40);
    f = '{8'hBB, 8'h67};
    send(f, 0);
    check_frame("no_timeout", 1, 0, '{8'hAA, 8'hBB});
`endif

    // Reset mid-payload aborts silently.
    f = '{HDR, 8'h04, 8'h01, 8'h02};
    send(f, 0);
    rst = 1'b0;
    tick(1'b1, 8'h03);
    check("rst_mid_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_mid_pulses", {30'd0, pkt_done, pkt_err}, 32'd0);
    check("rst_mid_pkt_len", {27'd0, pkt_len}, 32'd0);
    rst = 1'b1;
    exp_len = 5'd0;
    clear_obs();
    f = '{HDR, 8'h01, 8'h05, 8'h06};
    send(f, 0);
    check_frame("after_rst_mid", 1, 0, '{8'h05});

    // Reset mid-drain stops output immediately.
    send(build(rand_pl(6), 8'h06, 8'h00), 0);
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    check("drain_active", {31'd0, dout_valid}, 32'd1);
    rst = 1'b0;
    tick(1'b0, 8'h00);
    check("rst_drain_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_drain_dout", {24'd0, dout}, 32'd0);
    rst = 1'b1;
    exp_len = 5'd0;
    clear_obs();
    check_frame("after_rst_drain", 0, 0, '{});

    // Randomized frames with junk prefixes and gaps.
    for (int n = 0; n < 40; n++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        junk = 8'($urandom);
        if (junk == HDR) junk = 8'h00;
        tick(1'b1, junk);
      end
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        pl = rand_pl($urandom_range(1, MAX_LEN));
        send(build(pl, 8'(pl.size()), 8'h00), 2);
        check_frame("rnd_good", 1, 0, pl);
      end else if (kind == 2) begin
        pl = rand_pl($urandom_range(1, MAX_LEN));
        send(build(pl, 8'(pl.size()), 8'($urandom_range(1, 255))), 2);
        check_frame("rnd_bad_chk", 0, 1, '{});
      end else begin
        f = '{HDR, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255))};
        send(f, 2);
        check_frame("rnd_bad_len", 0, 1, '{});
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
